// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared helpers for the arbitrating multiplexer:
//               - clog2_min1 : channel-index width, never below 1 bit
//               - ptr_wrap   : next round-robin pointer with explicit wrap
//                              (safe for non-power-of-two channel counts)
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Returns idx+1, wrapping from n-1 back to 0.
    function automatic int ptr_wrap(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational grant selection over N request lines, either
//               round-robin (search starts at ptr) or fixed priority
//               (channel 0 highest). Holds the round-robin pointer and,
//               when ARB_LOCK_EN is defined, the burst lock state.
//               No data path.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_req[N]        - request vector
//               i_lock[N]       - lock request (ARB_LOCK_EN only)
//               i_load          - a transfer happens on this edge
//               o_grant_idx     - index of the winning channel
//               o_grant_valid   - some channel wins this cycle
// Config      : ARB_LOCK_EN     - enables i_lock and lock state
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int RR    = 1,
    parameter int SEL_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
`ifdef ARB_LOCK_EN
    input  logic [N-1:0]     i_lock,
`endif
    input  logic             i_load,
    output logic [SEL_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    localparam logic [N-1:0]   c_one = N'(1);
    localparam logic [SEL_W:0] c_n   = (SEL_W + 1)'(N);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W:0]   w_sum;
    logic [SEL_W-1:0] w_cand;
    logic [SEL_W-1:0] w_search_idx;
    logic             w_search_valid;
    logic [SEL_W-1:0] w_ptr_next;
    logic             w_ptr_adv;

    // Walk the channels in search order; the sum is one bit wider than the
    // index so the wrap compare also works when N is not a power of two.
    always_comb begin
        w_search_valid = 1'b0;
        w_search_idx   = '0;
        w_sum          = '0;
        w_cand         = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = ((RR != 0) ? {1'b0, r_ptr} : '0) + (SEL_W + 1)'(k);
            if (w_sum >= c_n) begin
                w_sum = w_sum - c_n;
            end
            w_cand = w_sum[SEL_W-1:0];
            if (!w_search_valid && (((i_req >> w_cand) & c_one) != '0)) begin
                w_search_valid = 1'b1;
                w_search_idx   = w_cand;
            end
        end
    end

`ifdef ARB_LOCK_EN
    logic             r_locked;
    logic [SEL_W-1:0] r_lock_idx;
    logic             w_lock_hit;

    // While locked only the owning channel may win; everyone else is masked.
    always_comb begin
        o_grant_valid = w_search_valid;
        o_grant_idx   = w_search_idx;
        if (r_locked) begin
            o_grant_valid = ((i_req >> r_lock_idx) & c_one) != '0;
            o_grant_idx   = r_lock_idx;
        end
    end

    assign w_lock_hit = ((i_lock >> o_grant_idx) & c_one) != '0;
    // The pointer only moves on the beat that ends (or never starts) a burst.
    assign w_ptr_adv  = i_load && !w_lock_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else if (i_load) begin
            r_locked <= w_lock_hit;
            if (w_lock_hit) begin
                r_lock_idx <= o_grant_idx;
            end
        end
    end
`else
    assign o_grant_valid = w_search_valid;
    assign o_grant_idx   = w_search_idx;
    assign w_ptr_adv     = i_load;
`endif

    assign w_ptr_next = SEL_W'(ptr_wrap(int'(o_grant_idx), N));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_ptr_adv) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux
// Description : N-channel valid/ready arbitrating multiplexer with a single
//               registered output stage (one word per cycle throughput).
// Ports       : clk, rst               - clock, synchronous active-high reset
//               in_valid[N]            - per-channel request
//               in_data[N*WIDTH]       - channel i at [i*WIDTH +: WIDTH]
//               in_ready[N]            - one-hot (or zero) accept
//               out_valid/out_data     - output register
//               out_sel[SEL_W]         - source channel of out_data
//               out_ready              - downstream accept
//               in_lock[N]             - burst lock (ARB_LOCK_EN only)
// Config      : ARB_LOCK_EN            - adds in_lock and grant locking
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int RR    = 1,
    parameter int SEL_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
`ifdef ARB_LOCK_EN
    ,
    input  logic [N-1:0]       in_lock
`endif
);

    localparam logic [N-1:0] c_one = N'(1);

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_sel;

    logic [SEL_W-1:0]   w_grant_idx;
    logic               w_grant_valid;
    logic               w_can_load;
    logic               w_load;
    logic [WIDTH-1:0]   w_sel_data;

    rr_arbiter #(
        .N     (N),
        .RR    (RR),
        .SEL_W (SEL_W)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_req         (in_valid),
`ifdef ARB_LOCK_EN
        .i_lock        (in_lock),
`endif
        .i_load        (w_load),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // Register can take a word when empty or being drained this cycle.
    // Reset suppresses acceptance so no beat is lost on the reset edge.
    assign w_can_load = !r_out_valid || out_ready;
    assign w_load     = w_grant_valid && w_can_load && !rst;

    always_comb begin
        in_ready = '0;
        if (w_load) begin
            in_ready = c_one << w_grant_idx;
        end
    end

    // Data select only feeds the register, never an output directly.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_grant_idx;
        end else if (out_ready) begin
            // Drain without refill: data and sel keep their last values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_mux
// Description : Scoreboard bench for arb_mux. Three instances: N=4 round
//               robin, N=4 fixed priority, N=3 round robin. Each has a
//               directed prologue (reset, fairness/priority/wrap, stall,
//               drain+load) followed by random traffic, with expected words
//               queued by a reference model and popped by a monitor.
// Config      : ARB_LOCK_EN - drives in_lock and models burst locking
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux;

    localparam int W       = 32;
    localparam int NUM_CYC = 320;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int NN  = (gi == 2) ? 3 : 4;
        localparam int RRV = (gi == 1) ? 0 : 1;
        localparam int SW  = (NN > 1) ? $clog2(NN) : 1;

        logic            rst;
        logic [NN-1:0]   in_valid;
        logic [NN-1:0]   in_ready;
        logic [NN*W-1:0] in_data;
        logic [NN-1:0]   in_lock;
        logic            out_valid;
        logic            out_ready;
        logic [W-1:0]    out_data;
        logic [SW-1:0]   out_sel;

        bit done   = 1'b0;
        bit mon_on = 1'b0;

        // Reference model state
        int            m_ptr;
        int            m_lock_idx;
        bit            m_full;
        bit            m_locked;
        bit [NN-1:0]   acc;
        logic [W-1:0]  q_data[$];
        int            q_sel[$];

        arb_mux #(
            .WIDTH (W),
            .N     (NN),
            .RR    (RRV)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_data   (in_data),
            .in_ready  (in_ready),
            .out_valid (out_valid),
            .out_data  (out_data),
            .out_sel   (out_sel),
            .out_ready (out_ready)
`ifdef ARB_LOCK_EN
            ,
            .in_lock   (in_lock)
`endif
        );

        function automatic string nm(input string s);
            return $sformatf("cfg%0d/%s", gi, s);
        endfunction

        // Winner by the arbitration rules; -1 when nobody may win.
        function automatic int grant_of(input logic [NN-1:0] v);
`ifdef ARB_LOCK_EN
            if (m_locked) return v[m_lock_idx] ? m_lock_idx : -1;
`endif
            for (int k = 0; k < NN; k++) begin
                int c;
                c = (RRV != 0) ? (m_ptr + k) % NN : k;
                if (v[c]) return c;
            end
            return -1;
        endfunction

        function automatic logic [NN-1:0] exp_ready();
            int g;
            g = grant_of(in_valid);
            if (rst || g < 0 || (m_full && !out_ready)) return '0;
            return NN'(1) << g;
        endfunction

        // Directed request patterns for the prologue.
        function automatic logic [NN-1:0] dir_mask(input int c);
            if (gi == 1) return (c < 8) ? NN'(10) : NN'(8);
            if (gi == 2) return (c < 2) ? NN'(4) : ((c < 4) ? NN'(1) : '1);
            return '1;
        endfunction

        // Called on each rising edge with the inputs the DUT sees there.
        task automatic model_step();
            int g;
            acc = '0;
            if (rst) begin
                m_full   = 1'b0;
                m_ptr    = 0;
                m_locked = 1'b0;
                q_data.delete();
                q_sel.delete();
            end else begin
                g = grant_of(in_valid);
                if (g >= 0 && (!m_full || out_ready)) begin
                    q_data.push_back(in_data[g*W +: W]);
                    q_sel.push_back(g);
                    m_full = 1'b1;
                    acc[g] = 1'b1;
`ifdef ARB_LOCK_EN
                    m_locked = in_lock[g];
                    if (in_lock[g]) m_lock_idx = g;
                    else            m_ptr = (g + 1) % NN;
`else
                    m_ptr = (g + 1) % NN;
`endif
                end else if (m_full && out_ready) begin
                    m_full = 1'b0;
                end
            end
        endtask

        task automatic drive(input int c);
            rst     = 1'b0;
            in_lock = '0;
            if (c < 12) begin
                out_ready = 1'b1;
                in_valid  = dir_mask(c);
            end else if (c < 15) begin
                out_ready = 1'b0;
                in_valid  = dir_mask(c);
            end else if (c == 15) begin
                out_ready = 1'b1;
                in_valid  = dir_mask(c);
            end else if (c < NUM_CYC - 12) begin
                rst       = ($urandom_range(0, 79) == 0);
                out_ready = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < NN; i++) begin
                    // A pending request keeps its word until accepted.
                    if (!(in_valid[i] && !acc[i])) begin
                        in_valid[i]         = ($urandom_range(0, 2) != 0);
                        in_data[i*W +: W]   = $urandom();
                    end
`ifdef ARB_LOCK_EN
                    in_lock[i] = ($urandom_range(0, 3) == 0);
`endif
                end
            end else begin
                in_valid  = '0;
                out_ready = 1'b1;
            end
        endtask

        // Stimulus and per-cycle in_ready checking
        initial begin
            rst       = 1'b1;
            out_ready = 1'b1;
            in_lock   = '0;
            in_valid  = '1;
            for (int i = 0; i < NN; i++) in_data[i*W +: W] = W'(32'hA0 + i);
            m_full     = 1'b0;
            m_ptr      = 0;
            m_locked   = 1'b0;
            m_lock_idx = 0;
            acc        = '0;
            repeat (2) begin
                @(posedge clk);
                model_step();
                #1;
                check(nm("rst_in_ready"),  64'(in_ready),  64'(0));
                check(nm("rst_out_valid"), 64'(out_valid), 64'(0));
                check(nm("rst_out_data"),  64'(out_data),  64'(0));
                check(nm("rst_out_sel"),   64'(out_sel),   64'(0));
            end
            mon_on = 1'b1;
            for (int c = 0; c < NUM_CYC; c++) begin
                @(negedge clk);
                drive(c);
                #1;
                check(nm("in_ready"), 64'(in_ready), 64'(exp_ready()));
                @(posedge clk);
                model_step();
            end
            @(negedge clk);
            #3;
            check(nm("leftover_words"), 64'(q_data.size()), 64'(0));
            check(nm("final_out_valid"), 64'(out_valid), 64'(0));
            done = 1'b1;
        end

        // Monitor: compares the presented word against the queue head and
        // retires it when the downstream accepts.
        initial forever begin
            @(negedge clk);
            #2;
            if (mon_on && !done) begin
                check(nm("out_valid"), 64'(out_valid), 64'(m_full));
                if (out_valid) begin
                    check(nm("word_expected"), 64'(q_data.size() != 0), 64'(1));
                    if (q_data.size() != 0) begin
                        check(nm("out_data"), 64'(out_data), 64'(q_data[0]));
                        check(nm("out_sel"),  64'(out_sel),  64'(q_sel[0]));
                        if (out_ready) begin
                            void'(q_data.pop_front());
                            void'(q_sel.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int t = 0; t < 5000 && !all_done; t++) begin
            @(posedge clk);
            all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done;
        end
        check("completion", 64'(all_done), 64'(1));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
